uart_rx_word_assembler: RTL and testbench
=========================================

# uart_rx_word_assembler

Downstream stage of `uart_receiver`: consumes received bytes and their error flags and assembles pairs of bytes into one 16-bit message word for the four-digit LED display driver (one hex nibble per digit). It guards the display against corrupted or half-received messages. Partial words are dropped on a receive error or an inter-byte timeout. The last good word is held until a new complete word arrives.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum clock cycles allowed between the first and second byte of a word (2 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Rx_DATA`  in  8  received byte from `uart_receiver`; sampled only on a `Rx_VALID` rising edge.
- `Rx_VALID`  in  1  receiver byte-valid (level or pulse); rising edge = new byte.
- `Rx_FERROR`  in  1  receiver framing error.
- `Rx_PERROR`  in  1  receiver parity error.
- `msg_data`  out  16  last complete word, `{byte0, byte1}` (first byte in [15:8]).
- `msg_valid`  out  1  high once any complete word has been captured since reset.
- `msg_update`  out  1  one-cycle pulse when `msg_data` changes.
- `msg_error`  out  1  high after a dropped word; cleared by the next complete word.
- `err_count`  out  8  saturating count of dropped words.

## Operation
- Edge detect: registered copies `valid_d`, `err_d`. `byte_evt = Rx_VALID & ~valid_d`, `err_evt = (Rx_FERROR|Rx_PERROR) & ~err_d`. Inputs are consumed directly (same clock domain as receiver).
- FSM, two states:
  - `WAIT_HI` (reset state): on `byte_evt` without `err_evt`, store `Rx_DATA` in `hi_reg`, clear timer, go `WAIT_LO`. On `err_evt`, perform a drop and stay.
  - `WAIT_LO`: timer increments each cycle. On `byte_evt` without `err_evt`, do a commit and go `WAIT_HI`. On `err_evt`, or when the timer reaches `TIMEOUT_CYCLES-1` with no `byte_evt`, do a drop and go `WAIT_HI`.
- Commit: `msg_data <= {hi_reg, Rx_DATA}`, `msg_valid <= 1`, `msg_update` pulses, `msg_error <= 0`.
- Drop: discards `hi_reg`. `msg_data` and `msg_valid` are unchanged. `msg_error <= 1`. `err_count` increments and saturates at 255.
- Simultaneous `byte_evt` and `err_evt`: the error wins and the byte is discarded.
- Timeout and `byte_evt` in the same cycle: the byte wins (commit).
- Timer width is `$clog2(TIMEOUT_CYCLES)`. It is held at 0 in `WAIT_HI`.

## Timing
- Reset values: `msg_data = 16'h0000`, `msg_valid = 0`, `msg_update = 0`, `msg_error = 0`, `err_count = 0`, state `WAIT_HI`, `hi_reg = 0`, timer 0, `valid_d = 0`, `err_d = 0`.
- Latency: `msg_data`, `msg_valid` and `msg_update` update on the clock edge after the cycle in which the second `Rx_VALID` rising edge is seen (1 cycle).
- Drop latency: 1 cycle after `err_evt` or after the timeout cycle.
- `msg_update` is exactly one cycle wide per commit. It is never asserted on a drop.
- A level `Rx_VALID` held high for many cycles yields exactly one byte.
- An error level held high yields exactly one drop.
- Reset mid-word: `hi_reg` is discarded, all outputs return to reset values immediately (asynchronous), and there is no `msg_update` pulse.
- No back-pressure: a commit overwrites the previous word unconditionally.

## Test plan
- Bytes `8'hA5` then `8'h3C`, 10 000 cycles apart -> `msg_data = 16'hA53C`; `msg_valid` and a single `msg_update` pulse 1 cycle after the second `Rx_VALID` edge; `msg_error = 0`.
- Byte `8'h12`, then `Rx_FERROR` pulse, then `8'h34`, `8'h56` -> first word dropped (`msg_error = 1`, `err_count = 1`); then `msg_data = 16'h3456`, `msg_error = 0`.
- `TIMEOUT_CYCLES = 50`: byte `8'hFF`, no second byte for 60 cycles -> drop at cycle 50 (`err_count = 1`, `msg_data` unchanged). Next two bytes `8'h01`, `8'h02` -> `16'h0102`.
- `Rx_VALID` held high 500 cycles with `Rx_DATA = 8'h77`, then a second rising edge with `8'h88` -> exactly one commit, `16'h7788`.
- `Rx_VALID` edge and `Rx_PERROR` edge in the same cycle in `WAIT_LO` -> drop, no `msg_update`, `err_count` increments.
- 300 consecutive error pulses -> `err_count` saturates at `8'hFF`.
- `reset` asserted mid-word -> all outputs return to reset values. A following fresh pair `8'hDE`, `8'hAD` -> `16'hDEAD`.

Source files
------------

// File: rtl/uart_rx_word_assembler.sv
// Pairs received UART bytes into 16-bit display words.
// Drops half words on a receive error or an inter-byte timeout.
module uart_rx_word_assembler #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic [15:0] msg_data,
  output logic        msg_valid,
  output logic        msg_update,
  output logic        msg_error,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          valid_d;
  logic          err_d;
  logic          byte_evt;
  logic          err_evt;
  logic [7:0]    hi_reg;
  logic [TW-1:0] timer;
  logic          load_hi;
  logic          commit;
  logic          drop;

  assign byte_evt = Rx_VALID & ~valid_d;
  assign err_evt  = (Rx_FERROR | Rx_PERROR) & ~err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_HI;
      valid_d <= 1'b0;
      err_d   <= 1'b0;
    end else begin
      state   <= next_state;
      valid_d <= Rx_VALID;
      err_d   <= Rx_FERROR | Rx_PERROR;
    end
  end

  // Errors beat bytes; a byte beats the timeout.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_HI: begin
        if (!err_evt && byte_evt)
          next_state = WAIT_LO;
      end
      WAIT_LO: begin
        if (err_evt || byte_evt || timer == TLAST)
          next_state = WAIT_HI;
      end
      default: next_state = WAIT_HI;
    endcase
  end

  always_comb begin
    load_hi = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state)
      WAIT_HI: begin
        drop    = err_evt;
        load_hi = ~err_evt & byte_evt;
      end
      WAIT_LO: begin
        drop   = err_evt | (~byte_evt & (timer == TLAST));
        commit = ~err_evt & byte_evt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer  <= '0;
      hi_reg <= 8'h00;
    end else begin
      if (state == WAIT_LO && next_state == WAIT_LO)
        timer <= timer + 1'b1;
      else
        timer <= '0;
      if (load_hi)
        hi_reg <= Rx_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_data   <= 16'h0000;
      msg_valid  <= 1'b0;
      msg_update <= 1'b0;
      msg_error  <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      msg_update <= commit;
      if (commit) begin
        msg_data  <= {hi_reg, Rx_DATA};
        msg_valid <= 1'b1;
        msg_error <= 1'b0;
      end
      if (drop) begin
        msg_error <= 1'b1;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Randomized and directed bench for uart_rx_word_assembler,
// checked against an event-level reference model.
module tb_uart_rx_word_assembler;

  localparam int T = 12000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  Rx_DATA = 8'h00;
  logic        Rx_VALID = 1'b0;
  logic        Rx_FERROR = 1'b0;
  logic        Rx_PERROR = 1'b0;
  logic [15:0] msg_data;
  logic        msg_valid;
  logic        msg_update;
  logic        msg_error;
  logic [7:0]  err_count;

  int n_assert = 0;
  int n_fail = 0;

  uart_rx_word_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_PERROR  (Rx_PERROR),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_update (msg_update),
    .msg_error  (msg_error),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Reference model: events, a pending byte and its arrival cycle.
  logic [15:0] m_data;
  logic        m_valid, m_upd, m_err;
  int          m_cnt;
  bit          pending, pv, pe, bev, eev;
  logic [7:0]  hi;
  longint      cyc, start;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = 16'h0; m_valid = 0; m_upd = 0; m_err = 0;
      m_cnt = 0; pending = 0; pv = 0; pe = 0; hi = 0;
      cyc = 0; start = 0;
    end else begin
      cyc++;
      bev = Rx_VALID && !pv;
      eev = (Rx_FERROR || Rx_PERROR) && !pe;
      pv = Rx_VALID;
      pe = Rx_FERROR || Rx_PERROR;
      m_upd = 0;
      if (eev) begin
        pending = 0;
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end else if (bev && pending) begin
        pending = 0;
        m_data = {hi, Rx_DATA};
        m_valid = 1; m_upd = 1; m_err = 0;
      end else if (bev) begin
        pending = 1; hi = Rx_DATA; start = cyc;
      end else if (pending && cyc - start == T) begin
        pending = 0;
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    n_assert++;
    if (msg_data !== m_data || msg_valid !== m_valid ||
        msg_update !== m_upd || msg_error !== m_err ||
        err_count !== m_cnt[7:0]) begin
      n_fail++;
      $display("FAIL model t=%0t got d=%h v=%b u=%b e=%b c=%h exp d=%h v=%b u=%b e=%b c=%h",
               $time, msg_data, msg_valid, msg_update, msg_error,
               err_count, m_data, m_valid, m_upd, m_err, m_cnt[7:0]);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic byte_on(input logic [7:0] b);
    Rx_DATA = b;
    Rx_VALID = 1'b1;
    tick(1);
    Rx_VALID = 1'b0;
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    byte_on(a);
    tick(1);
    byte_on(b);
    tick(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("reset_data", msg_data, 16'h0000);
    chk("reset_cnt", {8'h0, err_count}, 16'h0000);
    reset = 1'b0;
    tick(2);

    byte_on(8'hA5);
    tick(10000);
    byte_on(8'h3C);
    chk("a53c_data", msg_data, 16'hA53C);
    chk("a53c_upd", {15'h0, msg_update}, 16'h1);
    chk("a53c_err", {15'h0, msg_error}, 16'h0);
    tick(1);
    chk("a53c_upd_end", {15'h0, msg_update}, 16'h0);

    byte_on(8'h12);
    tick(2);
    Rx_FERROR = 1'b1;
    tick(1);
    Rx_FERROR = 1'b0;
    chk("ferr_err", {15'h0, msg_error}, 16'h1);
    chk("ferr_cnt", {8'h0, err_count}, 16'h0001);
    tick(1);
    pair(8'h34, 8'h56);
    chk("3456_data", msg_data, 16'h3456);
    chk("3456_err", {15'h0, msg_error}, 16'h0);

    byte_on(8'hFF);
    tick(T - 1);
    chk("to_pre_cnt", {8'h0, err_count}, 16'h0001);
    tick(1);
    chk("to_cnt", {8'h0, err_count}, 16'h0002);
    chk("to_data", msg_data, 16'h3456);
    chk("to_upd", {15'h0, msg_update}, 16'h0);
    tick(10);
    pair(8'h01, 8'h02);
    chk("0102_data", msg_data, 16'h0102);

    byte_on(8'h4B);
    tick(T - 1);
    byte_on(8'hC7);
    chk("edge_data", msg_data, 16'h4BC7);
    chk("edge_cnt", {8'h0, err_count}, 16'h0002);
    tick(2);

    Rx_DATA = 8'h77;
    Rx_VALID = 1'b1;
    tick(500);
    Rx_VALID = 1'b0;
    tick(1);
    chk("hold_data", msg_data, 16'h4BC7);
    byte_on(8'h88);
    chk("hold_commit", msg_data, 16'h7788);
    tick(1);

    byte_on(8'h5A);
    tick(1);
    Rx_DATA = 8'h99;
    Rx_VALID = 1'b1;
    Rx_PERROR = 1'b1;
    tick(1);
    Rx_VALID = 1'b0;
    Rx_PERROR = 1'b0;
    chk("sim_upd", {15'h0, msg_update}, 16'h0);
    chk("sim_data", msg_data, 16'h7788);
    chk("sim_cnt", {8'h0, err_count}, 16'h0003);
    tick(1);

    byte_on(8'h11);
    reset = 1'b1;
    #1;
    chk("mid_rst_data", msg_data, 16'h0000);
    chk("mid_rst_cnt", {8'h0, err_count}, 16'h0000);
    chk("mid_rst_val", {15'h0, msg_valid}, 16'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    pair(8'hDE, 8'hAD);
    chk("dead_data", msg_data, 16'hDEAD);

    for (int i = 0; i < 4000; i++) begin
      Rx_DATA = 8'($urandom);
      Rx_VALID = ($urandom_range(0, 3) == 0);
      Rx_FERROR = ($urandom_range(0, 19) == 0);
      Rx_PERROR = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    Rx_VALID = 1'b0;
    Rx_FERROR = 1'b0;
    Rx_PERROR = 1'b0;
    tick(2);

    for (int i = 0; i < 300; i++) begin
      Rx_FERROR = 1'b1;
      tick(1);
      Rx_FERROR = 1'b0;
      tick(1);
    end
    chk("sat_cnt", {8'h0, err_count}, 16'h00FF);
    chk("sat_err", {15'h0, msg_error}, 16'h1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
